obi_sram_arbiter: RTL and testbench

// - Shares one OBI SRAM data port (sram_d_* of the flip-flop RAM) among NUM_REQ OBI requesters:

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/obi_sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_obi_sram_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the OBI SRAM data-port arbiter.
package sram_arb_pkg;

  localparam int          NUM_REQ_MAX = 4;
  localparam logic [31:0] ERR_RDATA   = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [1:0] own;
    logic       we;
  } resp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first requester at or after ptr_i, searching modulo N.
// Purely combinational; returns one-hot grant, winner index and a valid flag.
module rr_arbiter import sram_arb_pkg::*; #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [1:0]   idx_o,
  output logic         valid_o
);

  logic [NUM_REQ_MAX-1:0] req_ext;
  logic [1:0]             cand;
  logic                   hit;

  // Scan candidates in priority order starting from the pointer.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req_i;
    idx_o          = 2'd0;
    valid_o        = 1'b0;
    cand           = 2'd0;
    hit            = 1'b0;
    gnt_o          = '0;
    for (int k = 0; k < N; k++) begin
      cand    = 2'((int'(ptr_i) + k) % N);
      hit     = ~valid_o & req_ext[cand];
      idx_o   = hit ? cand : idx_o;
      valid_o = valid_o | hit;
    end
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = valid_o & (idx_o == 2'(i));
    end
  end

endmodule

// File: rtl/obi_sram_arbiter.sv
// Shares one read-only-responding OBI SRAM port among NUM_REQ requesters with
// round-robin arbitration, stall locking and a one-deep response tag.
module obi_sram_arbiter #(
  parameter int          NUM_REQ   = 2,
  parameter int          RESP_LAT  = 1,
  parameter logic [31:0] ERR_RDATA = sram_arb_pkg::ERR_RDATA
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      s_req_i,
  output logic [NUM_REQ-1:0]      s_gnt_o,
  input  logic [NUM_REQ-1:0][31:0] s_addr_i,
  input  logic [NUM_REQ-1:0]      s_we_i,
  input  logic [NUM_REQ-1:0][3:0] s_be_i,
  input  logic [NUM_REQ-1:0][31:0] s_wdata_i,
  output logic [NUM_REQ-1:0]      s_rvalid_o,
  output logic [31:0]             s_rdata_o,
  output logic                    m_req_o,
  input  logic                    m_gnt_i,
  output logic [31:0]             m_addr_o,
  output logic                    m_we_o,
  output logic [3:0]              m_be_o,
  output logic [31:0]             m_wdata_o,
  input  logic                    m_rvalid_i,
  input  logic [31:0]             m_rdata_i,
  output logic                    protocol_err_o
);

  import sram_arb_pkg::*;

  if (RESP_LAT != 1 || NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_cfg
    $error("obi_sram_arbiter: unsupported NUM_REQ/RESP_LAT");
  end

  obi_req_t               req_ext [NUM_REQ_MAX];
  logic [NUM_REQ_MAX-1:0] req_vec_ext;

  // Widen requester ports to the maximum so a 2-bit index selects cleanly.
  for (genvar i = 0; i < NUM_REQ_MAX; i++) begin : g_ext
    if (i < NUM_REQ) begin : g_real
      assign req_ext[i]     = '{addr: s_addr_i[i], we: s_we_i[i], be: s_be_i[i], wdata: s_wdata_i[i]};
      assign req_vec_ext[i] = s_req_i[i];
    end else begin : g_tie
      assign req_ext[i]     = '0;
      assign req_vec_ext[i] = 1'b0;
    end
  end

  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic [1:0]         lock_idx_q, lock_idx_d;
  logic               pend_q, pend_d;
  resp_tag_t          tag_q, tag_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [1:0]         arb_idx;
  logic               arb_valid;
  logic [1:0]         win_idx;
  logic               hs;
  obi_req_t           sel;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req_i   (s_req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Winner selection, address-phase mux and upstream grant.
  always_comb begin
    win_idx = lock_q ? lock_idx_q : arb_idx;
    m_req_o = ~rst_i & (lock_q ? req_vec_ext[lock_idx_q] : arb_valid);
    hs      = m_req_o & m_gnt_i;
    sel       = req_ext[win_idx];
    m_addr_o  = sel.addr;
    m_we_o    = sel.we;
    m_be_o    = sel.be;
    m_wdata_o = sel.wdata;
    s_gnt_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_gnt_o[i] = hs & (lock_q ? (lock_idx_q == 2'(i)) : arb_gnt[i]);
    end
  end

  // Next-state: pointer advance, stall lock and response tag.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    pend_d     = hs;
    tag_d      = tag_q;
    if (hs) begin
      rr_ptr_d = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
      lock_d   = 1'b0;
      tag_d    = '{own: win_idx, we: m_we_o};
    end else if (m_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end else begin
      lock_d = lock_q;
    end
  end

  // Response routing; writes are answered locally, missing reads get ERR_RDATA.
  always_comb begin
    s_rvalid_o     = '0;
    s_rdata_o      = 32'h0000_0000;
    protocol_err_o = 1'b0;
    if (pend_q && !rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        s_rvalid_o[i] = (tag_q.own == 2'(i));
      end
      if (tag_q.we) begin
        s_rdata_o = 32'h0000_0000;
      end else if (m_rvalid_i) begin
        s_rdata_o = m_rdata_i;
      end else begin
        s_rdata_o      = ERR_RDATA;
        protocol_err_o = 1'b1;
      end
    end else begin
      s_rdata_o = 32'h0000_0000;
    end
    if (!rst_i && m_rvalid_i && (!pend_q || tag_q.we)) begin
      protocol_err_o = 1'b1;
    end else begin
      protocol_err_o = protocol_err_o;
    end
  end

  // State registers with synchronous reset; a pending response is discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= 2'd0;
      lock_q     <= 1'b0;
      lock_idx_q <= 2'd0;
      pend_q     <= 1'b0;
      tag_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      pend_q     <= pend_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// Directed bench for obi_sram_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever s_rvalid_o is presented.
module tb_obi_sram_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       s_req;
  logic [1:0]       s_gnt;
  logic [1:0][31:0] s_addr;
  logic [1:0]       s_we;
  logic [1:0][3:0]  s_be;
  logic [1:0][31:0] s_wdata;
  logic [1:0]       s_rvalid;
  logic [31:0]      s_rdata;
  logic             m_req;
  logic             m_gnt;
  logic [31:0]      m_addr;
  logic             m_we;
  logic [3:0]       m_be;
  logic [31:0]      m_wdata;
  logic             m_rvalid;
  logic [31:0]      m_rdata;
  logic             perr;

  obi_sram_arbiter #(.NUM_REQ(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_req_i        (s_req),
    .s_gnt_o        (s_gnt),
    .s_addr_i       (s_addr),
    .s_we_i         (s_we),
    .s_be_i         (s_be),
    .s_wdata_i      (s_wdata),
    .s_rvalid_o     (s_rvalid),
    .s_rdata_o      (s_rdata),
    .m_req_o        (m_req),
    .m_gnt_i        (m_gnt),
    .m_addr_o       (m_addr),
    .m_we_o         (m_we),
    .m_be_o         (m_be),
    .m_wdata_o      (m_wdata),
    .m_rvalid_i     (m_rvalid),
    .m_rdata_i      (m_rdata),
    .protocol_err_o (perr)
  );

  typedef struct {
    logic [1:0]  oh;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic drop_rsp   = 1'b0;
  logic inject_rv  = 1'b0;
  logic allow_unexp = 1'b0;
  logic        cap_rd;
  logic        cap_inj;
  logic [31:0] cap_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h8000_0010: mem_rd = 32'h1234_5678;
      32'h8000_0020: mem_rd = 32'hCAFE_F00D;
      32'h8000_0030: mem_rd = 32'h0BAD_C0DE;
      default:       mem_rd = 32'h0000_0000;
    endcase
  endfunction

  // SRAM model: a read handshake seen in cycle N returns data in cycle N+1.
  initial begin
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    cap_rd   = 1'b0;
    cap_inj  = 1'b0;
    cap_addr = 32'h0;
  end
  always @(negedge clk) begin
    cap_rd   = m_req & m_gnt & ~m_we & ~drop_rsp;
    cap_addr = m_addr;
    cap_inj  = inject_rv;
  end
  always @(posedge clk) begin
    #1;
    m_rvalid = cap_rd | cap_inj;
    m_rdata  = cap_rd ? mem_rd(cap_addr) : 32'h0;
  end

  // Response monitor.
  always @(negedge clk) begin
    if (s_rvalid != 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: rvalid=%b rdata=%h but none expected", s_rvalid, s_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_owner", {30'h0, s_rvalid}, {30'h0, e.oh});
        check("rsp_rdata", s_rdata, e.data);
        check("rsp_perr", {31'h0, perr}, {31'h0, e.err});
      end
    end else if (perr && !allow_unexp) begin
      checks++;
      errors++;
      $display("FAIL spurious_perr: protocol_err=1 required 0");
    end
  end

  task automatic push(input logic [1:0] oh, input logic [31:0] d, input logic err);
    exp_t e;
    e.oh = oh; e.data = d; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic r, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    s_req[i] = r; s_we[i] = we; s_addr[i] = a; s_be[i] = be; s_wdata[i] = wd;
  endtask

  // One cycle: check grant (and optionally address) at negedge, then move to next drive point.
  task automatic step(input string nm, input logic [1:0] eg, input logic chk_a, input logic [31:0] ea);
    @(negedge clk);
    check({nm, "_gnt"}, {30'h0, s_gnt}, {30'h0, eg});
    if (chk_a) check({nm, "_addr"}, m_addr, ea);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    m_gnt = 1'b1;
    s_req = 2'b00; s_we = 2'b00; s_be = '0; s_addr = '0; s_wdata = '0;
    set_req(0, 1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0);
    @(negedge clk);
    check("rst_m_req", {31'h0, m_req}, 32'h0);
    check("rst_gnt", {30'h0, s_gnt}, 32'h0);
    check("rst_rvalid", {30'h0, s_rvalid}, 32'h0);
    check("rst_perr", {31'h0, perr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read by req0.
    push(2'b01, 32'h1234_5678, 1'b0);
    step("rd0", 2'b01, 1'b1, 32'h8000_0010);
    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step("rd0_idle", 2'b00, 1'b0, 32'h0);

    // Stall with pointer at 1: req0 locks the port, req1 must wait.
    m_gnt = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0);
    step("stall0", 2'b00, 1'b1, 32'h8000_0010);
    set_req(1, 1'b1, 1'b0, 32'h8000_0030, 4'hF, 32'h0);
    step("stall1", 2'b00, 1'b1, 32'h8000_0010);
    step("stall2", 2'b00, 1'b1, 32'h8000_0010);
    m_gnt = 1'b1;
    push(2'b01, 32'h1234_5678, 1'b0);
    step("unstall0", 2'b01, 1'b1, 32'h8000_0010);
    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    push(2'b10, 32'h0BAD_C0DE, 1'b0);
    step("unstall1", 2'b10, 1'b1, 32'h8000_0030);

    // Continuous requests from both: grants alternate starting at req0.
    set_req(0, 1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h8000_0030, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push(2'b01, 32'hCAFE_F00D, 1'b0);
        step("alt", 2'b01, 1'b1, 32'h8000_0020);
      end else begin
        push(2'b10, 32'h0BAD_C0DE, 1'b0);
        step("alt", 2'b10, 1'b1, 32'h8000_0030);
      end
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Write by req1: response synthesised locally with zero data.
    set_req(1, 1'b1, 1'b1, 32'h8000_0040, 4'b0011, 32'h0000_55AA);
    push(2'b10, 32'h0, 1'b0);
    @(negedge clk);
    check("wr_gnt", {30'h0, s_gnt}, 32'h2);
    check("wr_we", {31'h0, m_we}, 32'h1);
    check("wr_be", {28'h0, m_be}, 32'h3);
    check("wr_wdata", m_wdata, 32'h0000_55AA);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step("wr_idle", 2'b00, 1'b0, 32'h0);

    // Missing read response.
    drop_rsp = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0);
    push(2'b01, 32'hDEAD_BEEF, 1'b1);
    step("miss", 2'b01, 1'b1, 32'h8000_0020);
    drop_rsp = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step("miss_idle", 2'b00, 1'b0, 32'h0);
    step("miss_idle2", 2'b00, 1'b0, 32'h0);

    // Unexpected response with nothing pending.
    inject_rv = 1'b1;
    step("unexp_arm", 2'b00, 1'b0, 32'h0);
    inject_rv = 1'b0;
    allow_unexp = 1'b1;
    @(negedge clk);
    check("unexp_perr", {31'h0, perr}, 32'h1);
    check("unexp_rvalid", {30'h0, s_rvalid}, 32'h0);
    @(posedge clk); #1;
    allow_unexp = 1'b0;

    // Reset right after a read grant: response discarded, pointer back to 0.
    set_req(0, 1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0);
    step("prerst", 2'b01, 1'b1, 32'h8000_0010);
    rst = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h8000_0030, 4'hF, 32'h0);
    @(negedge clk);
    check("midrst_m_req", {31'h0, m_req}, 32'h0);
    check("midrst_gnt", {30'h0, s_gnt}, 32'h0);
    check("midrst_rvalid", {30'h0, s_rvalid}, 32'h0);
    check("midrst_perr", {31'h0, perr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(2'b01, 32'h1234_5678, 1'b0);
    step("postrst0", 2'b01, 1'b1, 32'h8000_0010);
    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    push(2'b10, 32'h0BAD_C0DE, 1'b0);
    step("postrst1", 2'b10, 1'b1, 32'h8000_0030);
    set_req(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) step("tail", 2'b00, 1'b0, 32'h0);

    check("rsp_outstanding", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
